gameboy_button_driver: RTL and testbench

- Transmitter side of the gameboy button interface: accepts queued action requests (Kick/Punch/Jump/Duck/Run) and emits the button-code sequence on x that makes the gameboy FSM produce that action.
- Keeps a shadow copy of the game mode (IDLE/FIGHT/REACT), so each action gets the shortest press sequence.
- Sits between a scripted/CPU action source and the gameboy core. The core samples x only when x_valid=1.

---
 rtl/gameboy_pkg.sv | 53 +++++
 rtl/gameboy_button_driver_if.sv | 24 ++
 rtl/gameboy_act_fifo.sv | 52 +++++
 rtl/gameboy_button_driver.sv | 169 ++++++++++++++++
 tb/tb_gameboy_button_driver.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gameboy_pkg.sv
// Shared gameboy definitions: button, action and mode codes, and the mode
// transition rule used by both the gameboy core and the button driver.
package gameboy_pkg;

  localparam logic [1:0] BTN_FIGHT = 2'd0;
  localparam logic [1:0] BTN_REACT = 2'd1;
  localparam logic [1:0] BTN_A     = 2'd2;
  localparam logic [1:0] BTN_B     = 2'd3;

  localparam logic [2:0] ACT_KICK  = 3'd0;
  localparam logic [2:0] ACT_PUNCH = 3'd1;
  localparam logic [2:0] ACT_JUMP  = 3'd2;
  localparam logic [2:0] ACT_DUCK  = 3'd3;
  localparam logic [2:0] ACT_RUN   = 3'd4;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_FIGHT = 2'd1,
    MODE_REACT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_PRESS = 2'd1,
    SEQ_GAP   = 2'd2
  } seq_state_t;

  // Up to three presses; btn[0] is pressed first, len counts valid entries.
  typedef struct packed {
    logic [1:0]      len;
    logic [2:0][1:0] btn;
  } press_list_t;

  function automatic mode_t next_mode(input mode_t mode, input logic [1:0] button);
    mode_t m;
    case (mode)
      MODE_IDLE: begin
        if (button == BTN_FIGHT) begin
          m = MODE_FIGHT;
        end else if (button == BTN_REACT) begin
          m = MODE_REACT;
        end else begin
          m = MODE_IDLE;
        end
      end
      MODE_FIGHT: m = (button == BTN_FIGHT) ? MODE_IDLE : MODE_FIGHT;
      MODE_REACT: m = (button == BTN_REACT) ? MODE_IDLE : MODE_REACT;
      default:    m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gameboy_button_driver_if.sv
// Action-request and button-press signals between an action source (master)
// and the button driver (slave).
interface gameboy_button_driver_if;
  import gameboy_pkg::*;

  logic       act_valid;
  logic [2:0] act;
  logic       act_ready;
  logic       x_valid;
  logic [1:0] x;
  mode_t      mode;
  logic       done;
  logic       err;

  modport master (
    output act_valid, act,
    input  act_ready, x_valid, x, mode, done, err
  );

  modport slave (
    input  act_valid, act,
    output act_ready, x_valid, x, mode, done, err
  );
endinterface

// File: rtl/gameboy_act_fifo.sv
// Small synchronous FIFO holding queued action codes; pushes are ignored when
// full and pops when empty. Read data shows the head entry combinationally.
module gameboy_act_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/gameboy_button_driver.sv
// Turns queued actions into the shortest button-press sequence for the
// current (shadowed) gameboy mode, one press per x_valid cycle.
module gameboy_button_driver
  import gameboy_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PRESS_GAP  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  gameboy_button_driver_if.slave   bus
);
  localparam logic [3:0] GAP_LOAD = (PRESS_GAP == 0) ? 4'd0 : 4'(PRESS_GAP - 1);

  function automatic press_list_t build_presses(input logic [2:0] act, input mode_t m);
    press_list_t pl;
    logic [1:0]  last_btn;
    pl       = '0;
    last_btn = act[0] ? BTN_B : BTN_A;
    case (act)
      ACT_KICK, ACT_PUNCH: begin
        case (m)
          MODE_IDLE:  begin pl.len = 2'd2; pl.btn[0] = BTN_FIGHT; pl.btn[1] = last_btn; end
          MODE_REACT: begin
            pl.len = 2'd3; pl.btn[0] = BTN_REACT; pl.btn[1] = BTN_FIGHT; pl.btn[2] = last_btn;
          end
          default:    begin pl.len = 2'd1; pl.btn[0] = last_btn; end
        endcase
      end
      ACT_JUMP, ACT_DUCK: begin
        case (m)
          MODE_IDLE:  begin pl.len = 2'd2; pl.btn[0] = BTN_REACT; pl.btn[1] = last_btn; end
          MODE_FIGHT: begin
            pl.len = 2'd3; pl.btn[0] = BTN_FIGHT; pl.btn[1] = BTN_REACT; pl.btn[2] = last_btn;
          end
          default:    begin pl.len = 2'd1; pl.btn[0] = last_btn; end
        endcase
      end
      ACT_RUN: begin
        pl.len = 2'd1;
        case (m)
          MODE_FIGHT: pl.btn[0] = BTN_FIGHT;
          MODE_REACT: pl.btn[0] = BTN_REACT;
          default:    pl.btn[0] = BTN_A;
        endcase
      end
      default: pl = '0;
    endcase
    return pl;
  endfunction

  logic        w_full, w_empty, w_push, w_pop;
  logic [2:0]  w_head;
  seq_state_t  r_state, w_state_nxt;
  press_list_t r_list, w_list_nxt;
  logic [1:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic [3:0]  r_gap, w_gap_nxt;
  logic [1:0]  r_x, w_x_nxt, w_x_adv;
  mode_t       r_mode, w_mode_nxt;
  logic        r_done, w_done_nxt, w_done_adv;
  logic        r_err, w_err_nxt;
  logic        w_last;

  // Readiness looks only at the registered fill level, so a pop never frees a slot same-cycle.
  assign bus.act_ready = ~reset & ~w_full;
  assign w_push        = bus.act_valid & bus.act_ready;

  gameboy_act_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.act),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_idx_inc  = r_idx + 2'd1;
  assign w_x_adv    = r_list.btn[w_idx_inc];
  assign w_done_adv = (w_idx_inc == (r_list.len - 2'd1));
  assign w_last     = (r_idx == (r_list.len - 2'd1));

  // Sequencer next-state and next-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_list_nxt  = r_list;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_x_nxt     = r_x;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head > ACT_RUN) begin
            w_err_nxt = 1'b1;
          end else begin
            w_list_nxt  = build_presses(w_head, r_mode);
            w_idx_nxt   = 2'd0;
            w_x_nxt     = w_list_nxt.btn[0];
            w_done_nxt  = (w_list_nxt.len == 2'd1);
            w_state_nxt = SEQ_PRESS;
          end
        end else begin
          w_state_nxt = SEQ_IDLE;
        end
      end
      SEQ_PRESS: begin
        w_mode_nxt = next_mode(r_mode, r_x);
        if (PRESS_GAP != 0) begin
          w_state_nxt = SEQ_GAP;
          w_gap_nxt   = GAP_LOAD;
        end else if (w_last) begin
          w_state_nxt = SEQ_IDLE;
        end else begin
          w_idx_nxt  = w_idx_inc;
          w_x_nxt    = w_x_adv;
          w_done_nxt = w_done_adv;
        end
      end
      SEQ_GAP: begin
        if (r_gap != 4'd0) begin
          w_gap_nxt = r_gap - 4'd1;
        end else if (w_last) begin
          w_state_nxt = SEQ_IDLE;
        end else begin
          w_state_nxt = SEQ_PRESS;
          w_idx_nxt   = w_idx_inc;
          w_x_nxt     = w_x_adv;
          w_done_nxt  = w_done_adv;
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  // Sequencer state register; reset abandons any in-flight press list.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SEQ_IDLE;
      r_list  <= '0;
      r_idx   <= 2'd0;
      r_gap   <= 4'd0;
      r_x     <= BTN_FIGHT;
      r_mode  <= MODE_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_list  <= w_list_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_x     <= w_x_nxt;
      r_mode  <= w_mode_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.x_valid = (r_state == SEQ_PRESS);
  assign bus.x       = r_x;
  assign bus.mode    = r_mode;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_gameboy_button_driver.sv
// Directed bench for gameboy_button_driver: one instance without press gaps,
// one with PRESS_GAP=2.
module tb_gameboy_button_driver;
  import gameboy_pkg::*;

  logic clock = 1'b0;
  logic rst0  = 1'b1;
  logic rst1  = 1'b1;
  always #5 clock = ~clock;

  gameboy_button_driver_if bus0 ();
  gameboy_button_driver_if bus1 ();

  gameboy_button_driver #(.FIFO_DEPTH(4), .PRESS_GAP(0)) dut0 (
    .clock (clock), .reset (rst0), .bus (bus0));
  gameboy_button_driver #(.FIFO_DEPTH(4), .PRESS_GAP(2)) dut1 (
    .clock (clock), .reset (rst1), .bus (bus1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic [2:0] act;
    int         n;
    logic [1:0] b0, b1, b2;
    logic [1:0] mode;
  } vec_t;
  vec_t vecs[16];

  typedef struct {
    int         cyc;
    logic [1:0] x;
    logic       done;
  } press_t;
  press_t mon_q[$];
  bit     mon_en  = 1'b0;
  int     cyc_cnt = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clock) begin
    press_t p;
    if (mon_en && bus0.x_valid) begin
      p.cyc  = cyc_cnt;
      p.x    = bus0.x;
      p.done = bus0.done;
      mon_q.push_back(p);
    end
  end

  // Push one action into dut0 and follow its presses cycle by cycle.
  task automatic run_vec(input int v);
    vec_t       cv;
    logic [1:0] eb;
    cv = vecs[v];
    @(negedge clock);
    bus0.act_valid = 1'b1;
    bus0.act       = cv.act;
    @(negedge clock);
    bus0.act_valid = 1'b0;
    check($sformatf("v%0d_lat_xv", v), int'(bus0.x_valid), 0);
    for (int k = 1; k <= cv.n; k++) begin
      @(negedge clock);
      eb = (k == 1) ? cv.b0 : ((k == 2) ? cv.b1 : cv.b2);
      check($sformatf("v%0d_p%0d_xv", v, k), int'(bus0.x_valid), 1);
      check($sformatf("v%0d_p%0d_x", v, k), int'(bus0.x), int'(eb));
      check($sformatf("v%0d_p%0d_done", v, k), int'(bus0.done), int'(k == cv.n));
    end
    @(negedge clock);
    check($sformatf("v%0d_end_xv", v), int'(bus0.x_valid), 0);
    check($sformatf("v%0d_mode", v), int'(bus0.mode), int'(cv.mode));
  endtask

  logic [2:0] b2b_act[6];
  logic [1:0] b2b_btn[18];
  int         gap_xv[7]   = '{1, 0, 0, 1, 0, 0, 0};
  int         gap_done[7] = '{0, 0, 0, 1, 0, 0, 0};

  initial begin
    int   acc_cyc[6];
    int   i, guard, stall;
    logic will;

    vecs[0]  = '{ACT_KICK,  2, BTN_FIGHT, BTN_A,     BTN_A, MODE_FIGHT};
    vecs[1]  = '{ACT_JUMP,  3, BTN_FIGHT, BTN_REACT, BTN_A, MODE_REACT};
    vecs[2]  = '{ACT_RUN,   1, BTN_REACT, BTN_A,     BTN_A, MODE_IDLE};
    vecs[3]  = '{ACT_RUN,   1, BTN_A,     BTN_A,     BTN_A, MODE_IDLE};
    vecs[4]  = '{ACT_PUNCH, 2, BTN_FIGHT, BTN_B,     BTN_A, MODE_FIGHT};
    vecs[5]  = '{ACT_RUN,   1, BTN_FIGHT, BTN_A,     BTN_A, MODE_IDLE};
    vecs[6]  = '{ACT_DUCK,  2, BTN_REACT, BTN_B,     BTN_A, MODE_REACT};
    vecs[7]  = '{ACT_KICK,  3, BTN_REACT, BTN_FIGHT, BTN_A, MODE_FIGHT};
    vecs[8]  = '{ACT_DUCK,  3, BTN_FIGHT, BTN_REACT, BTN_B, MODE_REACT};
    vecs[9]  = '{ACT_PUNCH, 3, BTN_REACT, BTN_FIGHT, BTN_B, MODE_FIGHT};
    vecs[10] = '{ACT_KICK,  1, BTN_A,     BTN_A,     BTN_A, MODE_FIGHT};
    vecs[11] = '{ACT_RUN,   1, BTN_FIGHT, BTN_A,     BTN_A, MODE_IDLE};
    vecs[12] = '{ACT_JUMP,  2, BTN_REACT, BTN_A,     BTN_A, MODE_REACT};
    vecs[13] = '{ACT_JUMP,  1, BTN_A,     BTN_A,     BTN_A, MODE_REACT};
    vecs[14] = '{ACT_RUN,   1, BTN_REACT, BTN_A,     BTN_A, MODE_IDLE};
    vecs[15] = '{ACT_KICK,  2, BTN_FIGHT, BTN_A,     BTN_A, MODE_FIGHT};

    b2b_act = '{ACT_JUMP, ACT_KICK, ACT_DUCK, ACT_PUNCH, ACT_JUMP, ACT_KICK};
    b2b_btn = '{BTN_FIGHT, BTN_REACT, BTN_A, BTN_REACT, BTN_FIGHT, BTN_A,
                BTN_FIGHT, BTN_REACT, BTN_B, BTN_REACT, BTN_FIGHT, BTN_B,
                BTN_FIGHT, BTN_REACT, BTN_A, BTN_REACT, BTN_FIGHT, BTN_A};

    bus0.act_valid = 1'b0; bus0.act = 3'd0;
    bus1.act_valid = 1'b0; bus1.act = 3'd0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_ready0", int'(bus0.act_ready), 0);
    check("rst_ready1", int'(bus1.act_ready), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clock);
    check("rst_ready", int'(bus0.act_ready), 1);
    check("rst_xv", int'(bus0.x_valid), 0);
    check("rst_x", int'(bus0.x), 0);
    check("rst_mode", int'(bus0.mode), int'(MODE_IDLE));
    check("rst_done", int'(bus0.done), 0);
    check("rst_err", int'(bus0.err), 0);

    // PRESS_GAP=2: Duck from IDLE, then Run from REACT
    bus1.act_valid = 1'b1;
    bus1.act       = ACT_DUCK;
    @(negedge clock);
    bus1.act_valid = 1'b0;
    check("gap_k0_xv", int'(bus1.x_valid), 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check($sformatf("gap_k%0d_xv", k), int'(bus1.x_valid), gap_xv[k-1]);
      check($sformatf("gap_k%0d_done", k), int'(bus1.done), gap_done[k-1]);
      if (k == 1) check("gap_x1", int'(bus1.x), int'(BTN_REACT));
      if (k == 2) check("gap_mode2", int'(bus1.mode), int'(MODE_REACT));
      if (k == 4) check("gap_x4", int'(bus1.x), int'(BTN_B));
      if (k == 6) check("gap_x_hold", int'(bus1.x), int'(BTN_B));
    end
    check("gap_mode_end", int'(bus1.mode), int'(MODE_REACT));
    bus1.act_valid = 1'b1;
    bus1.act       = ACT_RUN;
    @(negedge clock);
    bus1.act_valid = 1'b0;
    check("gap_run_k0", int'(bus1.x_valid), 0);
    @(negedge clock);
    check("gap_run_xv", int'(bus1.x_valid), 1);
    check("gap_run_x", int'(bus1.x), int'(BTN_REACT));
    check("gap_run_done", int'(bus1.done), 1);
    @(negedge clock);
    check("gap_run_k2", int'(bus1.x_valid), 0);
    check("gap_run_mode", int'(bus1.mode), int'(MODE_IDLE));
    @(negedge clock);
    check("gap_run_k3", int'(bus1.x_valid), 0);

    // Table of single actions on dut0
    for (int v = 0; v < 16; v++) run_vec(v);

    // Six back-to-back three-press actions: queue fills and stalls once
    mon_q.delete();
    mon_en = 1'b1;
    @(negedge clock);
    i = 0; guard = 0; stall = 0;
    bus0.act_valid = 1'b1;
    bus0.act       = b2b_act[0];
    while (i < 6 && guard < 40) begin
      will = bus0.act_ready;
      @(negedge clock);
      guard++;
      if (will) begin
        acc_cyc[i] = cyc_cnt;
        i++;
        if (i < 6) bus0.act = b2b_act[i];
        else bus0.act_valid = 1'b0;
      end else begin
        stall++;
      end
    end
    check("b2b_accepts", i, 6);
    check("b2b_stall_cycles", stall, 1);
    if (i == 6) begin
      for (int j = 1; j < 5; j++)
        check($sformatf("b2b_acc%0d_gap", j), acc_cyc[j] - acc_cyc[j-1], 1);
      check("b2b_acc5_gap", acc_cyc[5] - acc_cyc[4], 2);
    end
    repeat (30) @(negedge clock);
    mon_en = 1'b0;
    check("b2b_press_count", mon_q.size(), 18);
    if (mon_q.size() == 18 && i == 6) begin
      check("b2b_first_lat", mon_q[0].cyc - acc_cyc[0], 1);
      for (int j = 0; j < 18; j++) begin
        check($sformatf("b2b_p%0d_x", j), int'(mon_q[j].x), int'(b2b_btn[j]));
        check($sformatf("b2b_p%0d_done", j), int'(mon_q[j].done), int'(j % 3 == 2));
        check($sformatf("b2b_p%0d_cyc", j), mon_q[j].cyc - mon_q[0].cyc, (j / 3) * 4 + (j % 3));
      end
    end
    check("b2b_mode", int'(bus0.mode), int'(MODE_FIGHT));

    // Reset during the second press of Jump from FIGHT
    @(negedge clock);
    bus0.act_valid = 1'b1;
    bus0.act       = ACT_JUMP;
    @(negedge clock);
    bus0.act_valid = 1'b0;
    @(negedge clock);
    check("mid_p1_x", int'(bus0.x), int'(BTN_FIGHT));
    @(negedge clock);
    check("mid_p2_xv", int'(bus0.x_valid), 1);
    check("mid_p2_x", int'(bus0.x), int'(BTN_REACT));
    rst0 = 1'b1;
    @(negedge clock);
    check("mid_rst_xv", int'(bus0.x_valid), 0);
    check("mid_rst_mode", int'(bus0.mode), int'(MODE_IDLE));
    check("mid_rst_ready", int'(bus0.act_ready), 0);
    rst0 = 1'b0;
    @(negedge clock);
    check("mid_post_ready", int'(bus0.act_ready), 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_post_xv%0d", k), int'(bus0.x_valid), 0);
      @(negedge clock);
    end

    // Illegal code 6 followed by Punch from IDLE
    bus0.act_valid = 1'b1;
    bus0.act       = 3'd6;
    @(negedge clock);
    bus0.act = ACT_PUNCH;
    check("ill_k0_err", int'(bus0.err), 0);
    @(negedge clock);
    bus0.act_valid = 1'b0;
    check("ill_k1_err", int'(bus0.err), 1);
    check("ill_k1_xv", int'(bus0.x_valid), 0);
    check("ill_k1_mode", int'(bus0.mode), int'(MODE_IDLE));
    @(negedge clock);
    check("ill_k2_err", int'(bus0.err), 0);
    check("ill_k2_xv", int'(bus0.x_valid), 1);
    check("ill_k2_x", int'(bus0.x), int'(BTN_FIGHT));
    @(negedge clock);
    check("ill_k3_x", int'(bus0.x), int'(BTN_B));
    check("ill_k3_done", int'(bus0.done), 1);
    @(negedge clock);
    check("ill_k4_xv", int'(bus0.x_valid), 0);
    check("ill_k4_mode", int'(bus0.mode), int'(MODE_FIGHT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
